// File: rtl/bsg_link_wormhole_mux.sv
// Packet-level round-robin mux merging wormhole streams into one registered flit stream.
// Define BSG_LINK_WORMHOLE_MUX_PERF_EN to add per-input packet and output stall counters.
module bsg_link_wormhole_mux #(
    parameter int width_p     = 16,
    parameter int num_in_p    = 2,
    parameter int len_width_p = 4
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [num_in_p-1:0][width_p-1:0]   data_i,
    input  logic [num_in_p-1:0]                v_i,
    output logic [num_in_p-1:0]                ready_and_o,
    output logic [width_p-1:0]                 data_o,
    output logic                               v_o,
    input  logic                               ready_and_i
`ifdef BSG_LINK_WORMHOLE_MUX_PERF_EN
   ,output logic [num_in_p-1:0][31:0]          pkt_count_o,
    output logic [31:0]                        stall_count_o
`endif
);

    localparam int lg_num_in_lp = (num_in_p > 1) ? $clog2(num_in_p) : 1;

    typedef logic [lg_num_in_lp-1:0] idx_t;
    typedef logic [len_width_p-1:0]  len_t;
    typedef enum logic {IDLE, BUSY} state_e;

    if (len_width_p > width_p) begin : g_bad_len
        $error("len_width_p must not exceed width_p");
    end
    if (num_in_p < 1) begin : g_bad_num
        $error("num_in_p must be at least 1");
    end

    function automatic idx_t inc_idx(idx_t x);
        if (x == idx_t'(num_in_p - 1)) return '0;
        return x + idx_t'(1);
    endfunction

    function automatic idx_t wrap_add(idx_t base, int off);
        int s;
        s = int'(base) + off;
        if (s >= num_in_p) s = s - num_in_p;
        return idx_t'(s);
    endfunction

    state_e state_r, state_n;
    idx_t   rr_r, rr_n;
    idx_t   owner_r, owner_n;
    len_t   cnt_r, cnt_n;
    idx_t   grant, sel, k;
    len_t   len;
    logic   found;
    logic   acc;
    logic   tail;

    logic [width_p-1:0] mem_r [2];
    logic               wptr_r, rptr_r;
    logic [1:0]         count_r;
    logic               buf_ready;
    logic               buf_empty;
    logic               deq;

    // Rotating priority search starting at rr_r.
    always_comb begin
        grant = rr_r;
        found = 1'b0;
        k     = '0;
        for (int i = 0; i < num_in_p; i++) begin
            k = wrap_add(rr_r, i);
            if (!found && v_i[k]) begin
                grant = k;
                found = 1'b1;
            end
        end
    end

    assign sel       = (state_r == BUSY) ? owner_r : grant;
    assign len       = data_i[sel][len_width_p-1:0];
    assign buf_ready = (count_r != 2'd2);
    assign buf_empty = (count_r == 2'd0);

    always_comb begin
        ready_and_o = '0;
        if (!reset_i) ready_and_o[sel] = buf_ready;
    end

    assign acc = v_i[sel] & ready_and_o[sel];

    always_comb begin
        state_n = state_r;
        rr_n    = rr_r;
        cnt_n   = cnt_r;
        owner_n = owner_r;
        tail    = 1'b0;
        unique case (state_r)
            IDLE: begin
                if (acc) begin
                    if (len == '0) begin
                        rr_n = inc_idx(grant);
                        tail = 1'b1;
                    end else begin
                        cnt_n   = len;
                        owner_n = grant;
                        state_n = BUSY;
                    end
                end
            end
            BUSY: begin
                if (acc) begin
                    cnt_n = cnt_r - len_t'(1);
                    if (cnt_r == len_t'(1)) begin
                        state_n = IDLE;
                        rr_n    = inc_idx(owner_r);
                        tail    = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= IDLE;
            rr_r    <= '0;
            cnt_r   <= '0;
            owner_r <= '0;
        end else begin
            state_r <= state_n;
            rr_r    <= rr_n;
            cnt_r   <= cnt_n;
            owner_r <= owner_n;
        end
    end

    // Two-entry output buffer; a full buffer refuses enqueue even on dequeue.
    assign v_o    = ~buf_empty & ~reset_i;
    assign deq    = v_o & ready_and_i;
    assign data_o = mem_r[rptr_r];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wptr_r  <= 1'b0;
            rptr_r  <= 1'b0;
            count_r <= 2'd0;
        end else begin
            if (acc) wptr_r <= ~wptr_r;
            if (deq) rptr_r <= ~rptr_r;
            unique case ({acc, deq})
                2'b10:   count_r <= count_r + 2'd1;
                2'b01:   count_r <= count_r - 2'd1;
                default: count_r <= count_r;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (acc) mem_r[wptr_r] <= data_i[sel];
    end

`ifdef BSG_LINK_WORMHOLE_MUX_PERF_EN
    logic [num_in_p-1:0][31:0] pkt_count_r;
    logic [31:0]               stall_count_r;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pkt_count_r   <= '0;
            stall_count_r <= '0;
        end else begin
            if (tail) pkt_count_r[sel] <= pkt_count_r[sel] + 32'd1;
            if (v_o & ~ready_and_i) stall_count_r <= stall_count_r + 32'd1;
        end
    end

    assign pkt_count_o   = pkt_count_r;
    assign stall_count_o = stall_count_r;
`else
    logic unused_tail;
    assign unused_tail = tail;
`endif

endmodule

// File: tb/tb_bsg_link_wormhole_mux.sv
// Scoreboard bench for bsg_link_wormhole_mux: packet-level reference plus directed grant-order checks.
module tb_bsg_link_wormhole_mux;

    localparam int W = 16;
    localparam int N = 3;
    localparam int L = 4;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [N-1:0][W-1:0] data_i;
    logic [N-1:0]       v_i;
    logic [N-1:0]       ready_and_o;
    logic [W-1:0]       data_o;
    logic               v_o;
    logic               ready_and_i = 1'b1;
`ifdef BSG_LINK_WORMHOLE_MUX_PERF_EN
    logic [N-1:0][31:0] pkt_count_o;
    logic [31:0]        stall_count_o;
`endif

    logic [W-1:0] drv_data [N];
    logic         drv_v    [N];

    always_comb begin
        for (int i = 0; i < N; i++) begin
            data_i[i] = drv_data[i];
            v_i[i]    = drv_v[i];
        end
    end

    bsg_link_wormhole_mux #(.width_p(W), .num_in_p(N), .len_width_p(L)) dut (
        .clk_i       (clk),
        .reset_i     (reset),
        .data_i      (data_i),
        .v_i         (v_i),
        .ready_and_o (ready_and_o),
        .data_o      (data_o),
        .v_o         (v_o),
        .ready_and_i (ready_and_i)
`ifdef BSG_LINK_WORMHOLE_MUX_PERF_EN
       ,.pkt_count_o   (pkt_count_o),
        .stall_count_o (stall_count_o)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    logic [W-1:0] drv_q [N][$];
    logic [W-1:0] src_q [N][$];
    int           ord_q [$];
    int           out_cyc [$];
    int           in0_cyc [$];
    int           seq [N];
    int           sent [N];
    int           tb_pkts [N];
    int           tb_stall;
    bit           hold [N];
    bit           rnd_hold = 1'b0;
    bit           lock_chk = 1'b0;
    int           rem = 0;
    int           cur = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_drv
        initial begin
            bit acc;
            drv_v[g]    = 1'b0;
            drv_data[g] = '0;
            forever begin
                @(negedge clk);
                acc = drv_v[g] && ready_and_o[g];
                if (acc && g == 0) in0_cyc.push_back(cyc);
                @(posedge clk);
                #1;
                if (acc && drv_q[g].size() > 0) void'(drv_q[g].pop_front());
                if (rnd_hold) hold[g] = ($urandom_range(3) == 0);
                drv_v[g]    = (drv_q[g].size() > 0) && !hold[g];
                drv_data[g] = (drv_q[g].size() > 0) ? drv_q[g][0] : '0;
            end
        end
    end

    // Output monitor: every packet must appear whole and in per-source order.
    always @(negedge clk) begin
        logic [W-1:0] e;
        int s;
        if (reset) begin
            chk("v_o_in_reset", v_o, 0);
            chk("ready_in_reset", ready_and_o, 0);
            rem      = 0;
            tb_stall = 0;
            for (int i = 0; i < N; i++) tb_pkts[i] = 0;
        end else begin
            if (v_o && !ready_and_i) tb_stall++;
            if (lock_chk && drv_q[0].size() > 0) chk("lock_hold", ready_and_o[1], 0);
            if (v_o && ready_and_i) begin
                out_cyc.push_back(cyc);
                s = (rem == 0) ? int'(data_o[15:14]) : cur;
                if (s >= N || src_q[s].size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL unexpected_flit: got %h, expected no flit", data_o);
                end else begin
                    e = src_q[s].pop_front();
                    if (rem == 0) begin
                        chk("header", data_o, e);
                        if (ord_q.size() > 0) chk("grant_order", s, ord_q.pop_front());
                        rem = int'(e[3:0]);
                        cur = s;
                        if (rem == 0) tb_pkts[s]++;
                    end else begin
                        chk("body", data_o, e);
                        rem--;
                        if (rem == 0) tb_pkts[s]++;
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic sync_push();
        @(negedge clk);
        #1;
    endtask

    task automatic send_pkt(input int i, input int len);
        logic [W-1:0] f;
        for (int k = 0; k <= len; k++) begin
            f = {2'(i), 6'(seq[i]), 4'(k), (k == 0) ? 4'(len) : 4'($urandom)};
            drv_q[i].push_back(f);
            src_q[i].push_back(f);
        end
        seq[i]++;
        sent[i]++;
    endtask

    task automatic hit_reset(input int n);
        reset = 1'b1;
        for (int i = 0; i < N; i++) begin
            drv_q[i].delete();
            src_q[i].delete();
            hold[i] = 1'b0;
            sent[i] = 0;
        end
        ord_q.delete();
        step(n);
        reset = 1'b0;
        step(1);
    endtask

    function automatic bit idle();
        bit r;
        r = (rem == 0);
        for (int i = 0; i < N; i++)
            if (drv_q[i].size() != 0 || src_q[i].size() != 0) r = 1'b0;
        return r;
    endfunction

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (!idle() && k < budget) begin
            step(1);
            k++;
        end
        chk(name, idle(), 1);
        chk("order_consumed", ord_q.size(), 0);
    endtask

    task automatic check_counts();
        for (int i = 0; i < N; i++) chk("pkts_out", tb_pkts[i], sent[i]);
`ifdef BSG_LINK_WORMHOLE_MUX_PERF_EN
        for (int i = 0; i < N; i++) chk("pkt_count", pkt_count_o[i], sent[i]);
        chk("stall_count", stall_count_o, tb_stall);
`endif
    endtask

    initial begin
        int guard;
        for (int i = 0; i < N; i++) begin
            hold[i] = 1'b0;
            seq[i]  = 0;
            sent[i] = 0;
        end
        step(3);
        reset = 1'b0;
        step(1);
        chk("idle_v_o", v_o, 0);

        // single packet, one-cycle latency per flit
        in0_cyc.delete();
        out_cyc.delete();
        sync_push();
        send_pkt(0, 3);
        drain("t1_drain", 50);
        chk("t1_count", out_cyc.size(), 4);
        if (out_cyc.size() == 4 && in0_cyc.size() == 4)
            for (int k = 0; k < 4; k++) chk("t1_latency", out_cyc[k], in0_cyc[k] + 1);
        step(1);
        chk("t1_v_o_after", v_o, 0);

        // two simultaneous packets, no bubble between them
        hit_reset(2);
        out_cyc.delete();
        sync_push();
        send_pkt(0, 2);
        send_pkt(1, 2);
        ord_q = '{0, 1};
        drain("t2_drain", 50);
        chk("t2_count", out_cyc.size(), 6);
        if (out_cyc.size() == 6) chk("t2_gapless", out_cyc[5] - out_cyc[0], 5);

        // pointer now at 2: input 2 beats input 0
        sync_push();
        send_pkt(0, 0);
        send_pkt(2, 0);
        ord_q = '{2, 0};
        drain("t2b_drain", 50);

        // owner bubble keeps the lock
        hit_reset(2);
        sync_push();
        send_pkt(0, 5);
        send_pkt(1, 1);
        ord_q = '{0, 1};
        lock_chk = 1'b1;
        guard = 0;
        while (drv_q[0].size() > 4 && guard < 50) begin
            step(1);
            guard++;
        end
        chk("t3_started", guard < 50, 1);
        hold[0] = 1'b1;
        step(3);
        hold[0] = 1'b0;
        drain("t3_drain", 80);
        lock_chk = 1'b0;

        // downstream stall: buffer holds exactly two flits
        hit_reset(2);
        ready_and_i = 1'b0;
        sync_push();
        send_pkt(0, 7);
        step(10);
        chk("t4_accepted", 8 - drv_q[0].size(), 2);
        chk("t4_ready_low", ready_and_o, 0);
        ready_and_i = 1'b1;
        drain("t4_drain", 50);
        check_counts();

        // back-to-back single-flit packets rotate grant
        hit_reset(2);
        out_cyc.delete();
        sync_push();
        send_pkt(0, 0);
        send_pkt(1, 0);
        send_pkt(2, 0);
        send_pkt(0, 0);
        ord_q = '{0, 1, 2, 0};
        drain("t5_drain", 50);
        chk("t5_count", out_cyc.size(), 4);
        if (out_cyc.size() == 4) chk("t5_gapless", out_cyc[3] - out_cyc[0], 3);

        // reset mid-packet discards it
        hit_reset(2);
        sync_push();
        send_pkt(0, 6);
        guard = 0;
        while (drv_q[0].size() > 4 && guard < 50) begin
            step(1);
            guard++;
        end
        hit_reset(3);
        out_cyc.delete();
        sync_push();
        send_pkt(1, 1);
        ord_q = '{1};
        drain("t6_drain", 50);
        chk("t6_count", out_cyc.size(), 2);
        check_counts();

        // random traffic, bubbles and backpressure
        rnd_hold = 1'b1;
        for (int p = 0; p < 200; ) begin
            step(1);
            ready_and_i = ($urandom_range(3) != 0);
            if (drv_q[0].size() + drv_q[1].size() + drv_q[2].size() < 40) begin
                send_pkt($urandom_range(N - 1), $urandom_range(15));
                p++;
            end
        end
        rnd_hold = 1'b0;
        for (int i = 0; i < N; i++) hold[i] = 1'b0;
        step(1);
        ready_and_i = 1'b1;
        drain("rand_drain", 5000);
        check_counts();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
